dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Controller that shares the single-port 32-word data memory between the MEM-stage load/store port and a loader/debug port.
- Sequences each access: registered address/data/enable to the memory, waits the memory's read latency, then returns data.
- Stalls the pipeline while a MEM-stage access is pending.
- Sits between the MEM stage and the data memory array, which becomes a plain synchronous RAM.

Parameters:
- ADDR_W, 5, word-address width; memory depth is 2**ADDR_W.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..4.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- cpu_rd  in  1  MEM-stage load request (m[1])
- cpu_wr  in  1  MEM-stage store request (m[0])
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_stall falls
- cpu_stall  out  1  freeze pipeline
- ldr_req  in  1  loader request, held until ldr_gnt
- ldr_we  in  1  1 = write, 0 = read
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_gnt  out  1  one-cycle grant pulse
- ldr_rvalid  out  1  one-cycle loader read-data strobe
- ldr_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset are as stated in Ports: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - All outputs 0; FSM in IDLE; lat_cnt 0.
  - last_owner = LDR, so the CPU wins the first tie.
  - Async assertion drops mem_en/mem_we immediately and aborts any transaction; no grant or rvalid is emitted for it.
- FSM states:
  - IDLE: cpu_req = cpu_rd|cpu_wr.
    - Only one requester active: select it.
    - Both active: select the one not equal to last_owner.
    - Go to ISSUE, registering mem_* from the selected port.
  - ISSUE (1 cycle): mem_en=1 and mem_we set per request.
    - Loader owner: ldr_gnt=1 in this cycle.
    - Write: go to DONE.
    - Read: lat_cnt=MEM_LAT, go to WAIT.
  - WAIT: decrement lat_cnt each cycle. On the edge where it reaches 0, capture mem_rdata into cpu_rdata (CPU owner) or ldr_rdata with ldr_rvalid=1 for one cycle (loader owner), then go to DONE.
  - DONE (1 cycle): update last_owner; cpu_stall=0 if owner is CPU; go to IDLE.
- cpu_stall:
  - Combinational: cpu_req & ~(state==DONE & owner==CPU).
  - A CPU request therefore stalls through IDLE, ISSUE and WAIT, including while the loader owns the memory.
- Uncontended CPU latency (request seen in cycle 0):
  - Write: mem_en in cycle 1, stall low in cycle 2.
  - Read: mem_en in cycle 1, stall low in cycle 2+MEM_LAT, with cpu_rdata valid from that cycle.
- Loader read: ldr_rvalid asserts exactly MEM_LAT+1 cycles after ldr_gnt.
- Loader inputs must be stable while ldr_req=1 and no grant has been given; the loader may re-request in the cycle after ldr_gnt.
- cpu_rd & cpu_wr both high: treated as a write; the read is ignored (simulation assertion fires).
- CPU request dropped mid-transaction (flush): the access still completes, cpu_rdata is updated, and the FSM returns to IDLE normally. A write already issued is not cancelled.
- Back-to-back CPU accesses: a new request is sampled in IDLE on the cycle after DONE; there is no overlap of transactions.
- Round-robin fairness: with both ports requesting continuously, grants alternate CPU, LDR, CPU...
- Addresses are used as-is, with no wrap or bounds logic.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With the macro defined, add these ports:
  - stats_clr in 1: synchronous clear.
  - conflict_cnt out 16: cycles in IDLE with both ports requesting; saturating at 0xFFFF.
  - stall_cnt out 16: cycles with cpu_stall=1; saturating at 0xFFFF.
  - Both counters reset to 0.
- Without the macro: these ports and counters are absent; no functional change.

Test Plan:
- MEM_LAT=1, no loader; CPU write addr 5 data 0xDEADBEEF in cycle 0 -> mem_en=mem_we=1, mem_addr=5 in cycle 1; cpu_stall high in cycles 0-1, low in cycle 2.
- Follow-up CPU read of addr 5 -> mem_en=1, mem_we=0 in cycle 1; cpu_stall low in cycle 3; cpu_rdata=0xDEADBEEF.
- After reset, with RAM preloaded identity: CPU read addr 3 and loader write 0x12345678 to addr 3 in the same cycle -> CPU served first with cpu_rdata=3; ldr_gnt in the following ISSUE. The next simultaneous tie grants the loader.
- Loader-only reads of addr 7 then addr 8, MEM_LAT=3 -> each ldr_rvalid 4 cycles after its ldr_gnt, with ldr_rdata=7 then 8; cpu_stall stays 0.
- CPU read with rst_n pulsed low during WAIT -> mem_en and cpu_stall drop immediately and no rvalid occurs; after release, the held request re-issues from IDLE and completes with the correct data.
- DMEM_ARB_STATS_EN defined; two simultaneous requests, then stats_clr -> conflict_cnt=1 and stall_cnt equals the counted stall cycles; both read 0 the cycle after clear.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU load/store, loader/debug and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ldr_gnt, ldr_rvalid, ldr_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, ldr_gnt, ldr_rvalid, ldr_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer sharing a synchronous data RAM between the MEM stage and a loader.
// Defining DMEM_ARB_STATS_EN adds saturating conflict/stall counters with a synchronous clear.
module dmem_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  dmem_arbiter_if.master bus
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] conflict_cnt,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t     state, nxt;
  logic [2:0] lat_cnt;
  logic       own, last_ldr, cpu_req, go, sel_ldr, stall, last_beat;
  assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign go        = cpu_req | bus.ldr_req;
  // last_ldr=1 means the loader owned the previous access, so a tie goes to the CPU
  assign sel_ldr   = bus.ldr_req & (~cpu_req | ~last_ldr);
  assign last_beat = state == WAIT && lat_cnt == 3'd1;
  assign stall     = rst_n & cpu_req & ~(state == DONE & ~own);
  assign bus.cpu_stall = stall;
  always_comb
    nxt = state == IDLE  ? (go ? ISSUE : IDLE) :
          state == ISSUE ? (bus.mem_we ? DONE : WAIT) :
          state == WAIT  ? (last_beat ? DONE : WAIT) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.ldr_gnt    <= 1'b0;
      bus.ldr_rvalid <= 1'b0;
      bus.ldr_rdata  <= '0;
      bus.cpu_rdata  <= '0;
      lat_cnt        <= 3'd0;
      own            <= 1'b0;
      last_ldr       <= 1'b1;
    end else begin
      bus.mem_en     <= state == IDLE && go;
      bus.mem_we     <= state == IDLE && go && (sel_ldr ? bus.ldr_we : bus.cpu_wr);
      bus.ldr_gnt    <= state == IDLE && sel_ldr;
      bus.ldr_rvalid <= last_beat && own;
      if (state == IDLE && go) begin
        bus.mem_addr  <= ADDR_W'(sel_ldr ? bus.ldr_addr : bus.cpu_addr);
        bus.mem_wdata <= DATA_W'(sel_ldr ? bus.ldr_wdata : bus.cpu_wdata);
        own           <= sel_ldr;
      end
      if (state == ISSUE) lat_cnt <= 3'(MEM_LAT);
      else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;
      if (last_beat && own) bus.ldr_rdata <= DATA_W'(bus.mem_rdata);
      if (last_beat && !own) bus.cpu_rdata <= DATA_W'(bus.mem_rdata);
      if (state == DONE) last_ldr <= own;
    end
  // simultaneous load and store is served as a store
  assert property (@(posedge clk) disable iff (!rst_n) !(bus.cpu_rd && bus.cpu_wr));
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      conflict_cnt <= 16'd0;
      stall_cnt    <= 16'd0;
    end else if (stats_clr) begin
      conflict_cnt <= 16'd0;
      stall_cnt    <= 16'd0;
    end else begin
      if (state == IDLE && cpu_req && bus.ldr_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule
